// File: rtl/mem_level.sv
// Memory stage: word-organised data memory with byte/half/word loads and stores,
// WB-to-store-data forwarding, and the MEM/WB pipeline register.
module mem_level #(
    parameter int DM_WORDS    = 4096,
    parameter int DM_AW       = 12,
    parameter int WIDTH_INSTR = 6,
    parameter int WIDTH_T     = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stall,
    input  logic                   clr,
    input  logic [WIDTH_INSTR-1:0] instr_MEM,
    input  logic [31:0]            PC_MEM,
    input  logic [31:0]            aluOut_MEM,
    input  logic [31:0]            memWriteData_MEM,
    input  logic [4:0]             addrRt_MEM,
    input  logic [4:0]             regWriteAddr_MEM,
    input  logic [31:0]            regWriteData_MEM,
    input  logic [WIDTH_T-1:0]     Tnew_MEM,
    input  logic [4:0]             regaddr_WB,
    input  logic [31:0]            regdata_WB,
    output logic [4:0]             regaddr_MEM,
    output logic [31:0]            regdata_MEM,
    output logic [WIDTH_INSTR-1:0] instr_WB,
    output logic [31:0]            PC_WB,
    output logic [4:0]             regWriteAddr_WB,
    output logic [31:0]            regWriteData_WB,
    output logic [WIDTH_T-1:0]     Tnew_WB
);

    // Instruction encodings shared with the decoder.
    localparam logic [WIDTH_INSTR-1:0] I_LW  = WIDTH_INSTR'(10);
    localparam logic [WIDTH_INSTR-1:0] I_LH  = WIDTH_INSTR'(11);
    localparam logic [WIDTH_INSTR-1:0] I_LHU = WIDTH_INSTR'(12);
    localparam logic [WIDTH_INSTR-1:0] I_LB  = WIDTH_INSTR'(13);
    localparam logic [WIDTH_INSTR-1:0] I_LBU = WIDTH_INSTR'(14);
    localparam logic [WIDTH_INSTR-1:0] I_SW  = WIDTH_INSTR'(15);
    localparam logic [WIDTH_INSTR-1:0] I_SH  = WIDTH_INSTR'(16);
    localparam logic [WIDTH_INSTR-1:0] I_SB  = WIDTH_INSTR'(17);

    logic [31:0]      dm [DM_WORDS];
    logic [DM_AW-1:0] idx;
    logic [31:0]      cur_word, wd, new_word, load_val, wdata_next;
    logic [15:0]      half;
    logic [7:0]       bsel;
    logic             is_store, is_load;
    logic [WIDTH_T-1:0] tnew_next;
    logic             unused_addr_bits;

    assign idx      = aluOut_MEM[DM_AW+1:2];
    assign cur_word = dm[idx];
    assign unused_addr_bits = ^aluOut_MEM[31:DM_AW+2];

    assign wd = (regaddr_WB == addrRt_MEM && regaddr_WB != 5'd0) ? regdata_WB : memWriteData_MEM;

    assign regaddr_MEM = (Tnew_MEM == '0) ? regWriteAddr_MEM : 5'd0;
    assign regdata_MEM = regWriteData_MEM;

    assign half = aluOut_MEM[1] ? cur_word[31:16] : cur_word[15:0];

    always_comb begin
        bsel = cur_word[7:0];
        case (aluOut_MEM[1:0])
            2'd1:    bsel = cur_word[15:8];
            2'd2:    bsel = cur_word[23:16];
            2'd3:    bsel = cur_word[31:24];
            default: bsel = cur_word[7:0];
        endcase
    end

    // Merge store data into the current word so untouched lanes are preserved.
    always_comb begin
        new_word = cur_word;
        is_store = 1'b1;
        case (instr_MEM)
            I_SW: new_word = wd;
            I_SH: if (aluOut_MEM[1]) new_word[31:16] = wd[15:0];
                  else               new_word[15:0]  = wd[15:0];
            I_SB: case (aluOut_MEM[1:0])
                      2'd0:    new_word[7:0]   = wd[7:0];
                      2'd1:    new_word[15:8]  = wd[7:0];
                      2'd2:    new_word[23:16] = wd[7:0];
                      default: new_word[31:24] = wd[7:0];
                  endcase
            default: is_store = 1'b0;
        endcase
    end

    always_comb begin
        load_val = cur_word;
        is_load  = 1'b1;
        case (instr_MEM)
            I_LW:    load_val = cur_word;
            I_LH:    load_val = {{16{half[15]}}, half};
            I_LHU:   load_val = {16'd0, half};
            I_LB:    load_val = {{24{bsel[7]}}, bsel};
            I_LBU:   load_val = {24'd0, bsel};
            default: is_load = 1'b0;
        endcase
    end

    assign wdata_next = is_load ? load_val : regWriteData_MEM;
    assign tnew_next  = (Tnew_MEM == '0) ? '0 : Tnew_MEM - 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DM_WORDS; i++) dm[i] <= '0;
        end else if (is_store && !clr && !stall) begin
            dm[idx] <= new_word;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            instr_WB        <= '0;
            PC_WB           <= '0;
            regWriteAddr_WB <= '0;
            regWriteData_WB <= '0;
            Tnew_WB         <= '0;
        end else if (!stall) begin
            instr_WB        <= instr_MEM;
            PC_WB           <= PC_MEM;
            regWriteAddr_WB <= regWriteAddr_MEM;
            regWriteData_WB <= wdata_next;
            Tnew_WB         <= tnew_next;
        end
    end

endmodule

// File: tb/tb_mem_level.sv
// Directed bench for mem_level: loads/stores, forwarding, stall/clr, wrap, Tnew.
module tb_mem_level;

    localparam int DM_WORDS = 4096;
    localparam logic [5:0] ADDU = 6'd1,  LW = 6'd10, LH = 6'd11, LHU = 6'd12,
                           LB   = 6'd13, LBU = 6'd14, SW = 6'd15, SH = 6'd16, SB = 6'd17;

    logic        clk = 1'b0;
    logic        reset, stall, clr;
    logic [5:0]  instr_MEM;
    logic [31:0] PC_MEM, aluOut_MEM, memWriteData_MEM, regWriteData_MEM, regdata_WB;
    logic [4:0]  addrRt_MEM, regWriteAddr_MEM, regaddr_WB;
    logic [1:0]  Tnew_MEM;
    logic [4:0]  regaddr_MEM, regWriteAddr_WB;
    logic [31:0] regdata_MEM, PC_WB, regWriteData_WB;
    logic [5:0]  instr_WB;
    logic [1:0]  Tnew_WB;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] pc = 32'h0000_3000;

    mem_level #(.DM_WORDS(DM_WORDS), .DM_AW(12), .WIDTH_INSTR(6), .WIDTH_T(2)) dut (
        .clk(clk), .reset(reset), .stall(stall), .clr(clr),
        .instr_MEM(instr_MEM), .PC_MEM(PC_MEM), .aluOut_MEM(aluOut_MEM),
        .memWriteData_MEM(memWriteData_MEM), .addrRt_MEM(addrRt_MEM),
        .regWriteAddr_MEM(regWriteAddr_MEM), .regWriteData_MEM(regWriteData_MEM),
        .Tnew_MEM(Tnew_MEM), .regaddr_WB(regaddr_WB), .regdata_WB(regdata_WB),
        .regaddr_MEM(regaddr_MEM), .regdata_MEM(regdata_MEM), .instr_WB(instr_WB),
        .PC_WB(PC_WB), .regWriteAddr_WB(regWriteAddr_WB),
        .regWriteData_WB(regWriteData_WB), .Tnew_WB(Tnew_WB)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [5:0] ins, input logic [31:0] a, input logic [31:0] mwd,
                         input logic [4:0] rt, input logic [4:0] rd, input logic [31:0] rwd,
                         input logic [1:0] tn);
        instr_MEM = ins; aluOut_MEM = a; memWriteData_MEM = mwd; addrRt_MEM = rt;
        regWriteAddr_MEM = rd; regWriteData_MEM = rwd; Tnew_MEM = tn;
        PC_MEM = pc;
        pc = pc + 32'd4;
    endtask

    task automatic ld(input string tag, input logic [5:0] ins, input logic [31:0] a,
                      input logic [31:0] exp);
        drive(ins, a, 32'd0, 5'd0, 5'd4, 32'h0, 2'd1);
        tick();
        chk(tag, regWriteData_WB, exp);
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; clr = 1'b0;
        regaddr_WB = 5'd0; regdata_WB = 32'h0;
        drive(SW, 32'h10, 32'hFFFF_FFFF, 5'd0, 5'd9, 32'h1234, 2'd2);
        tick();
        chk("rst_instr", 32'(instr_WB), 32'h0);
        chk("rst_pc", PC_WB, 32'h0);
        chk("rst_addr", 32'(regWriteAddr_WB), 32'h0);
        chk("rst_data", regWriteData_WB, 32'h0);
        chk("rst_tnew", 32'(Tnew_WB), 32'h0);
        reset = 1'b0;

        ld("lw_after_rst", LW, 32'h10, 32'h0);
        chk("lw_instr", 32'(instr_WB), 32'(LW));

        drive(SW, 32'h20, 32'h89AB_CDEF, 5'd0, 5'd0, 32'h0, 2'd0);
        tick();
        ld("lb_23", LB, 32'h23, 32'hFFFF_FF89);
        ld("lbu_23", LBU, 32'h23, 32'h0000_0089);
        ld("lb_20", LB, 32'h20, 32'hFFFF_FFEF);
        ld("lbu_21", LBU, 32'h21, 32'h0000_00CD);
        ld("lb_22", LB, 32'h22, 32'hFFFF_FFAB);
        ld("lh_22", LH, 32'h22, 32'hFFFF_89AB);
        ld("lhu_20", LHU, 32'h20, 32'h0000_CDEF);
        ld("lh_21", LH, 32'h21, 32'hFFFF_CDEF);
        ld("lw_23", LW, 32'h23, 32'h89AB_CDEF);

        drive(SB, 32'h21, 32'hFFFF_FF55, 5'd0, 5'd0, 32'h0, 2'd0);
        tick();
        ld("sb_21", LW, 32'h20, 32'h89AB_55EF);
        drive(SH, 32'h22, 32'hFFFF_1234, 5'd0, 5'd0, 32'h0, 2'd0);
        tick();
        ld("sh_22", LW, 32'h20, 32'h1234_55EF);

        // Store followed directly by load sees new data.
        drive(SB, 32'h20, 32'h0000_00A0, 5'd0, 5'd0, 32'h0, 2'd0);
        tick();
        ld("sb_then_lbu", LBU, 32'h20, 32'h0000_00A0);

        regaddr_WB = 5'd8; regdata_WB = 32'hCAFE_BABE;
        drive(SW, 32'h30, 32'h0, 5'd8, 5'd0, 32'h0, 2'd0);
        tick();
        regaddr_WB = 5'd0;
        ld("fwd_hit", LW, 32'h30, 32'hCAFE_BABE);
        drive(SW, 32'h30, 32'h0, 5'd8, 5'd0, 32'h0, 2'd0);
        tick();
        ld("fwd_r0", LW, 32'h30, 32'h0);
        regdata_WB = 32'h0;

        drive(ADDU, 32'h55, 32'h0, 5'd0, 5'd3, 32'd7, 2'd0);
        #1;
        chk("fwd_addr_t0", 32'(regaddr_MEM), 32'd3);
        chk("fwd_data", regdata_MEM, 32'd7);
        tick();
        chk("addu_data", regWriteData_WB, 32'd7);
        chk("addu_tnew", 32'(Tnew_WB), 32'd0);
        chk("addu_rd", 32'(regWriteAddr_WB), 32'd3);
        chk("addu_pc", PC_WB, pc - 32'd4);

        stall = 1'b1;
        drive(SW, 32'h40, 32'hDEAD_BEEF, 5'd0, 5'd0, 32'h0, 2'd0);
        tick();
        chk("stall_instr", 32'(instr_WB), 32'(ADDU));
        chk("stall_data", regWriteData_WB, 32'd7);
        stall = 1'b0;
        ld("stall_nowrite", LW, 32'h40, 32'h0);

        clr = 1'b1;
        drive(SW, 32'h40, 32'hDEAD_BEEF, 5'd0, 5'd0, 32'h0, 2'd0);
        tick();
        chk("clr_instr", 32'(instr_WB), 32'h0);
        chk("clr_pc", PC_WB, 32'h0);
        chk("clr_data", regWriteData_WB, 32'h0);
        clr = 1'b0;
        ld("clr_nowrite", LW, 32'h40, 32'h0);

        drive(SW, 32'(4 * DM_WORDS + 4), 32'h1, 5'd0, 5'd0, 32'h0, 2'd0);
        tick();
        ld("wrap", LW, 32'h4, 32'h1);

        drive(LW, 32'h4, 32'h0, 5'd0, 5'd6, 32'h0, 2'd1);
        #1;
        chk("fwd_addr_t1", 32'(regaddr_MEM), 32'd0);
        tick();
        chk("load_tnew", 32'(Tnew_WB), 32'd0);
        drive(ADDU, 32'h0, 32'h0, 5'd0, 5'd6, 32'd9, 2'd2);
        tick();
        chk("tnew_dec", 32'(Tnew_WB), 32'd1);

        reset = 1'b1;
        drive(SW, 32'h50, 32'h77, 5'd0, 5'd0, 32'h0, 2'd0);
        tick();
        reset = 1'b0;
        ld("rst_discard", LW, 32'h50, 32'h0);
        ld("rst_clears", LW, 32'h20, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_level.md
Name: mem_level

Overview:
- Memory stage of the five-stage pipeline. It sits directly downstream of the execute stage and consumes that stage's MEM-side pipeline registers.
- Holds a word-organised data memory and executes loads and stores (word, half and byte), with sign or zero extension on loads.
- Forwards WB-stage results into store data.
- Drives the MEM/WB pipeline register.

Parameters:
- DM_WORDS, 4096, data memory depth in 32-bit words; must be a power of two.
- DM_AW, 12, word-index width, equal to log2(DM_WORDS).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- stall  in  1  hold the MEM/WB register; suppress the memory write.
- clr  in  1  load a bubble into the MEM/WB register; suppress the memory write.
- instr_MEM  in  WIDTH_INSTR  decoded instruction enum.
- PC_MEM  in  32  instruction address.
- aluOut_MEM  in  32  effective address for memory ops, otherwise the result.
- memWriteData_MEM  in  32  store data as captured in EX.
- addrRt_MEM  in  5  rt index, used for store-data forwarding.
- regWriteAddr_MEM  in  5  destination register.
- regWriteData_MEM  in  32  destination data produced so far.
- Tnew_MEM  in  WIDTH_T  cycles until the result is ready.
- regaddr_WB  in  5  WB-stage destination (forward source).
- regdata_WB  in  32  WB-stage write data.
- regaddr_MEM  out  5  this stage's forward address: regWriteAddr_MEM, or 0 when Tnew_MEM > 0.
- regdata_MEM  out  32  equal to regWriteData_MEM.
- instr_WB  out  WIDTH_INSTR  MEM/WB register.
- PC_WB  out  32  MEM/WB register.
- regWriteAddr_WB  out  5  MEM/WB register.
- regWriteData_WB  out  32  MEM/WB register.
- Tnew_WB  out  WIDTH_T  MEM/WB register.

Behaviour:
- Clock/reset: single clk; reset is synchronous and active-high.
- Reset:
  - All MEM/WB outputs go to 0.
  - Every data memory word is cleared to 0.
- Address: A = aluOut_MEM.
  - Word index is A[DM_AW+1:2]; upper bits are ignored, so addresses wrap modulo 4*DM_WORDS.
  - Halfword lane is A[1]; byte lane is A[1:0].
  - A[0] is ignored for halfwords and A[1:0] for words; there is no alignment exception.
- Store data forwarding (combinational):
  - wd = regdata_WB when regaddr_WB == addrRt_MEM and regaddr_WB != 0.
  - Otherwise wd = memWriteData_MEM.
- Stores: write at posedge only when reset=0, clr=0 and stall=0.
  - SW writes wd to the whole word.
  - SH writes wd[15:0] into the halfword selected by A[1].
  - SB writes wd[7:0] into the byte selected by A[1:0].
  - Untouched lanes keep their value.
- Loads are combinational reads of the current memory contents:
  - LW returns the word.
  - LH/LHU return the A[1] half, sign- or zero-extended.
  - LB/LBU return the A[1:0] byte, sign- or zero-extended.
  - Lane 0 is bits [7:0] (little-endian within the word).
- A store followed immediately by a load to the same word sees the new data, because the write lands at the edge before the load's cycle.
- Result selection:
  - regWriteData_next = load value for load instructions.
  - Otherwise regWriteData_next = regWriteData_MEM.
- Tnew: Tnew_next = Tnew_MEM - 1, saturating at 0.
- MEM/WB register, priority reset|clr > stall > load:
  - reset or clr: all outputs become 0 (bubble).
  - stall: all outputs hold.
  - Otherwise: register instr_MEM, PC_MEM, regWriteAddr_MEM, regWriteData_next and Tnew_next.
- Non-memory instructions pass through with no memory access.
- A bubble (instr 0) performs no write.
- Latency: one cycle from MEM inputs to WB outputs.
- Reset mid-operation: a store presented in the reset cycle is discarded.

Test Plan:
- Reset, then LW from address 0x10 -> regWriteData_WB = 0x00000000, and all WB outputs are 0 during reset.
- SW 0x89ABCDEF to 0x20, then LB/LBU/LH/LHU/LW at 0x20, 0x21, 0x22 and 0x23:
  - LB at 0x23 -> 0xFFFFFF89; LBU at 0x23 -> 0x00000089; LB at 0x20 -> 0xFFFFFFEF.
  - LH at 0x22 -> 0xFFFF89AB; LHU at 0x20 -> 0x0000CDEF; LW -> 0x89ABCDEF.
- SB 0x55 to 0x21 over 0x89ABCDEF -> LW returns 0x89AB55EF; SH 0x1234 to 0x22 -> 0x123455EF.
- SW with addrRt_MEM = 8, regaddr_WB = 8, regdata_WB = 0xCAFEBABE, memWriteData_MEM = 0 -> memory holds 0xCAFEBABE. Repeat with regaddr_WB = 0 -> memory holds 0.
- SW held with stall=1 -> no write and WB outputs unchanged. Same SW with clr=1 -> no write and WB outputs 0.
- Address wrap: SW 0x1 to 4*DM_WORDS + 4, then LW from 4 -> 0x00000001.
- ADDU passthrough with regWriteData_MEM = 7 and Tnew_MEM = 0:
  - regWriteData_WB = 7 and Tnew_WB = 0.
  - With Tnew_MEM = 1 (load): Tnew_WB = 0 and regaddr_MEM = 0 during MEM.
